// File: rtl/hexagon_render_pkg.sv
// Shared definitions for the convex polygon filler.
//   state_t : scan/fill FSM states, in traversal order
//   SLOPE_W : width of the signed fixed-point slope / inverse-slope words
//   sext64  : sign-extends a 32-bit word so products are formed at full 64-bit width
package hexagon_render_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_OFFSET_MUL, S_OFFSET_SUB, S_Y_RANGE, S_ROW_INIT,
        S_ISECT_MUL, S_ISECT_SEL, S_X_RANGE, S_BURST_SET, S_BURST,
        S_BURST_NEXT, S_ROW_NEXT, S_DONE
    } state_t;

    localparam int SLOPE_W = 32;

    function automatic logic signed [63:0] sext64(input logic signed [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/convex_polygon_filler_if.sv
// Burst request bus between the polygon filler and the pixel writer.
//   txn_init    : burst requested (held until txn_done)
//   txn_done    : one-cycle pulse, burst finished
//   x, y        : signed start pixel of the burst
//   pixel_count : burst length in pixels
interface convex_polygon_filler_if;
    logic               txn_init;
    logic               txn_done;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic [31:0]        pixel_count;

    modport master (output txn_init, x, y, pixel_count, input txn_done);
    modport slave  (input txn_init, x, y, pixel_count, output txn_done);
endinterface

// File: rtl/edge_intersect.sv
// Per-edge line evaluation for one polygon edge (vertex 0 -> vertex 1).
//   off_mul_i/off_sub_i     : compute offset b = vy0 - (m*vx0 >>> FRAC_BITS)
//   isect_mul_i/isect_sel_i : evaluate intersection with row y_i and edge validity
//   valid_o                 : edge crosses row y_i and is not horizontal
//   x_o                     : intersection x on row y_i
module edge_intersect
    import hexagon_render_pkg::*;
#(
    parameter int FRAC_BITS = 12
) (
    input  logic                      clk100,
    input  logic                      resetn,
    input  logic                      off_mul_i,
    input  logic                      off_sub_i,
    input  logic                      isect_mul_i,
    input  logic                      isect_sel_i,
    input  logic signed [31:0]        vx0_i,
    input  logic signed [31:0]        vy0_i,
    input  logic signed [31:0]        vx1_i,
    input  logic signed [31:0]        vy1_i,
    input  logic signed [SLOPE_W-1:0] m_i,
    input  logic signed [SLOPE_W-1:0] m_inv_i,
    input  logic signed [31:0]        y_i,
    output logic                      valid_o,
    output logic signed [31:0]        x_o
);
    logic signed [63:0] prod_q, iprod_q;
    logic signed [31:0] b_q, x_q;
    logic               valid_q;
    logic               horiz, vert, in_span;

    assign horiz   = (vy0_i == vy1_i);
    assign vert    = (vx0_i == vx1_i);
    assign in_span = (y_i >= vy0_i && y_i <= vy1_i) || (y_i >= vy1_i && y_i <= vy0_i);

    always_ff @(posedge clk100) begin
        if (!resetn) begin
            prod_q  <= '0;
            iprod_q <= '0;
            b_q     <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            if (off_mul_i)   prod_q  <= sext64(m_i) * sext64(vx0_i);
            if (off_sub_i)   b_q     <= vy0_i - 32'(prod_q >>> FRAC_BITS);
            if (isect_mul_i) iprod_q <= sext64(y_i - b_q) * sext64(m_inv_i);
            if (isect_sel_i) begin
                valid_q <= !horiz && in_span;
                // Endpoints and vertical edges bypass the lossy slope path.
                if (y_i == vy0_i)      x_q <= vx0_i;
                else if (y_i == vy1_i) x_q <= vx1_i;
                else if (vert)         x_q <= vx0_i;
                else                   x_q <= 32'(iprod_q >>> FRAC_BITS);
            end
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
endmodule

// File: rtl/convex_polygon_filler.sv
// Scanline filler for a convex polygon: walks rows y_min..y_max (clipped to the
// screen), finds the span of each row from the edge intersections and issues it
// as bursts of at most BURST_LEN pixels on the burst bus.
//   clk100, resetn        : clock, synchronous active-low reset
//   start, abort          : start (rising edge) / cancel a fill
//   vx_in, vy_in          : packed signed vertex coordinates, 32 bits per vertex
//   m_in, m_inv_in        : packed signed fixed-point slope / inverse slope per edge
//   bus (master)          : burst request bus
//   busy, done            : not idle / one-cycle completion pulse
module convex_polygon_filler
    import hexagon_render_pkg::*;
#(
    parameter int NUM_VERTS = 6,
    parameter int BURST_LEN = 128,
    parameter int FRAC_BITS = 12,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic                           clk100,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           abort,
    input  logic [32*NUM_VERTS-1:0]        vx_in,
    input  logic [32*NUM_VERTS-1:0]        vy_in,
    input  logic [SLOPE_W*NUM_VERTS-1:0]   m_in,
    input  logic [SLOPE_W*NUM_VERTS-1:0]   m_inv_in,
    convex_polygon_filler_if.master        bus,
    output logic                           busy,
    output logic                           done
);
    state_t                    state_q;
    logic                      start_q1, start_q2, busy_q, done_q, txn_init_q, abort_pend_q;
    logic signed [31:0]        vx_q [NUM_VERTS];
    logic signed [31:0]        vy_q [NUM_VERTS];
    logic signed [SLOPE_W-1:0] m_q [NUM_VERTS];
    logic signed [SLOPE_W-1:0] minv_q [NUM_VERTS];
    logic signed [31:0]        y_q, ymax_q, x_q, xmax_q;
    logic [31:0]               pc_q;

    logic [NUM_VERTS-1:0]      e_valid;
    logic signed [31:0]        e_x [NUM_VERTS];
    logic signed [31:0]        ymn, ymx, ymn_c, ymx_c, xmn, xmx, xmn_c, xmx_c, remain;
    logic                      any_v;

    for (genvar k = 0; k < NUM_VERTS; k++) begin : g_edge
        edge_intersect #(.FRAC_BITS(FRAC_BITS)) u_edge (
            .clk100     (clk100),
            .resetn     (resetn),
            .off_mul_i  (state_q == S_OFFSET_MUL),
            .off_sub_i  (state_q == S_OFFSET_SUB),
            .isect_mul_i(state_q == S_ISECT_MUL),
            .isect_sel_i(state_q == S_ISECT_SEL),
            .vx0_i      (vx_q[k]),
            .vy0_i      (vy_q[k]),
            .vx1_i      (vx_q[(k + 1) % NUM_VERTS]),
            .vy1_i      (vy_q[(k + 1) % NUM_VERTS]),
            .m_i        (m_q[k]),
            .m_inv_i    (minv_q[k]),
            .y_i        (y_q),
            .valid_o    (e_valid[k]),
            .x_o        (e_x[k])
        );
    end

    // Vertical extent of the polygon, clipped to the screen.
    always_comb begin
        ymn = vy_q[0];
        ymx = vy_q[0];
        for (int k = 1; k < NUM_VERTS; k++) begin
            if (vy_q[k] < ymn) ymn = vy_q[k];
            if (vy_q[k] > ymx) ymx = vy_q[k];
        end
        ymn_c = (ymn < 0) ? 32'sd0 : ymn;
        ymx_c = (ymx > SCREEN_H - 1) ? 32'(SCREEN_H - 1) : ymx;
    end

    // Row span over valid edges only, clipped to the screen.
    always_comb begin
        any_v = 1'b0;
        xmn   = 32'sh7fff_ffff;
        xmx   = 32'sh8000_0000;
        for (int k = 0; k < NUM_VERTS; k++) begin
            if (e_valid[k]) begin
                any_v = 1'b1;
                if (e_x[k] < xmn) xmn = e_x[k];
                if (e_x[k] > xmx) xmx = e_x[k];
            end
        end
        xmn_c  = (xmn < 0) ? 32'sd0 : xmn;
        xmx_c  = (xmx > SCREEN_W - 1) ? 32'(SCREEN_W - 1) : xmx;
        remain = xmax_q - x_q + 32'sd1;
    end

    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            start_q1     <= 1'b0;
            start_q2     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            txn_init_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            y_q          <= '0;
            ymax_q       <= '0;
            x_q          <= '0;
            xmax_q       <= '0;
            pc_q         <= '0;
            for (int k = 0; k < NUM_VERTS; k++) begin
                vx_q[k]   <= '0;
                vy_q[k]   <= '0;
                m_q[k]    <= '0;
                minv_q[k] <= '0;
            end
        end else begin
            start_q1 <= start;
            start_q2 <= start_q1;
            done_q   <= 1'b0;
            // Abort is immediate except during BURST, where it waits for txn_done.
            if (abort && state_q != S_IDLE && state_q != S_BURST) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                txn_init_q   <= 1'b0;
                abort_pend_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start_q1 && !start_q2) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                    S_LOAD: begin
                        for (int k = 0; k < NUM_VERTS; k++) begin
                            vx_q[k]   <= vx_in[32*k +: 32];
                            vy_q[k]   <= vy_in[32*k +: 32];
                            m_q[k]    <= m_in[SLOPE_W*k +: SLOPE_W];
                            minv_q[k] <= m_inv_in[SLOPE_W*k +: SLOPE_W];
                        end
                        state_q <= S_OFFSET_MUL;
                    end
                    S_OFFSET_MUL: state_q <= S_OFFSET_SUB;
                    S_OFFSET_SUB: state_q <= S_Y_RANGE;
                    S_Y_RANGE: if (ymn_c > ymx_c) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        y_q     <= ymn_c;
                        ymax_q  <= ymx_c;
                        state_q <= S_ROW_INIT;
                    end
                    S_ROW_INIT:  state_q <= S_ISECT_MUL;
                    S_ISECT_MUL: state_q <= S_ISECT_SEL;
                    S_ISECT_SEL: state_q <= S_X_RANGE;
                    S_X_RANGE: if (!any_v || xmn_c > xmx_c) begin
                        state_q <= S_ROW_NEXT;
                    end else begin
                        x_q     <= xmn_c;
                        xmax_q  <= xmx_c;
                        state_q <= S_BURST_SET;
                    end
                    S_BURST_SET: begin
                        pc_q       <= (remain > 32'(BURST_LEN)) ? 32'(BURST_LEN) : remain;
                        txn_init_q <= 1'b1;
                        state_q    <= S_BURST;
                    end
                    S_BURST: if (bus.txn_done) begin
                        txn_init_q   <= 1'b0;
                        abort_pend_q <= 1'b0;
                        if (abort_pend_q || abort) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_BURST_NEXT;
                        end
                    end else if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                    S_BURST_NEXT: if (x_q + BURST_LEN <= xmax_q) begin
                        x_q     <= x_q + BURST_LEN;
                        state_q <= S_BURST_SET;
                    end else begin
                        state_q <= S_ROW_NEXT;
                    end
                    S_ROW_NEXT: if (y_q < ymax_q) begin
                        y_q     <= y_q + 32'sd1;
                        state_q <= S_ROW_INIT;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.txn_init    = txn_init_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pixel_count = pc_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_convex_polygon_filler.sv
module tb_convex_polygon_filler;
    localparam int NV = 6;

    bit clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic              resetn, start, abort;
    logic [32*NV-1:0]  vx_in, vy_in, m_in, m_inv_in;
    logic              busy, done;

    convex_polygon_filler_if bus ();

    convex_polygon_filler #(
        .NUM_VERTS(NV), .BURST_LEN(128), .FRAC_BITS(12), .SCREEN_W(640), .SCREEN_H(480)
    ) dut (
        .clk100  (clk100),
        .resetn  (resetn),
        .start   (start),
        .abort   (abort),
        .vx_in   (vx_in),
        .vy_in   (vy_in),
        .m_in    (m_in),
        .m_inv_in(m_inv_in),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Burst monitor: records every burst at its first cycle, checks hold stability.
    int nb = 0;
    int rec_x [256];
    int rec_y [256];
    int rec_pc[256];
    int done_cnt = 0;
    int stable_err = 0;
    bit in_burst = 1'b0;
    int cur_x, cur_y, cur_pc;

    always @(negedge clk100) begin
        if (bus.txn_init) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                cur_x  = bus.x;
                cur_y  = bus.y;
                cur_pc = int'(bus.pixel_count);
                if (nb < 256) begin
                    rec_x[nb]  = cur_x;
                    rec_y[nb]  = cur_y;
                    rec_pc[nb] = cur_pc;
                end
                nb++;
            end else if (bus.x != cur_x || bus.y != cur_y || int'(bus.pixel_count) != cur_pc) begin
                stable_err++;
            end
        end else begin
            in_burst = 1'b0;
        end
        if (done) done_cnt++;
    end

    // Burst responder: pulses txn_done resp_delay cycles after txn_init rises.
    int resp_delay = 0;
    initial begin
        int cnt;
        cnt = 0;
        bus.txn_done = 1'b0;
        forever begin
            @(posedge clk100);
            #1;
            bus.txn_done = 1'b0;
            if (bus.txn_init) begin
                if (cnt >= resp_delay) begin
                    bus.txn_done = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    function automatic logic [32*NV-1:0] p6(input int a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    typedef struct packed {
        logic [32*NV-1:0] vx;
        logic [32*NV-1:0] vy;
        int e_n, e_pix, e_fy, e_ly, e_xlo, e_xhi;
        int e_x0, e_pc0, e_x1, e_pc1, e_x2, e_pc2, e_y2, e_lat;
    } vec_t;

    function automatic vec_t mk(input logic [32*NV-1:0] vx, vy,
                                input int n, pix, fy, ly, xlo, xhi,
                                input int x0, pc0, x1, pc1, x2, pc2, y2, lat);
        vec_t v;
        v.vx = vx; v.vy = vy;
        v.e_n = n; v.e_pix = pix; v.e_fy = fy; v.e_ly = ly; v.e_xlo = xlo; v.e_xhi = xhi;
        v.e_x0 = x0; v.e_pc0 = pc0; v.e_x1 = x1; v.e_pc1 = pc1; v.e_x2 = x2; v.e_pc2 = pc2;
        v.e_y2 = y2; v.e_lat = lat;
        return v;
    endfunction

    // Pulses start, waits (bounded) for done; optionally re-pulses start while busy.
    task automatic run_fill(input int restart_at, output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b1;
        @(posedge clk100);
        #2 start = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk100);
            #2;
            lat++;
            if (lat == 3) start = 1'b0;
            if (restart_at > 0 && lat == restart_at) start = 1'b1;
            if (restart_at > 0 && lat == restart_at + 3) start = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        repeat (8) @(posedge clk100);
        #2;
    endtask

    vec_t vecs[4];

    initial begin
        int  base, d0, s0, n, pix, xlo, xhi, lat, c;
        bit  to, seen;
        real yr, xl, xr, xs, xe;

        vecs[0] = mk(p6(10, 20, 20, 10, 10, 10), p6(10, 10, 20, 20, 20, 10),
                     11, 121, 10, 20, 10, 20, 10, 11, 10, 11, 10, 11, 12, 5000);
        vecs[1] = mk(p6(100, 399, 399, 100, 100, 100), p6(5, 5, 6, 6, 6, 5),
                     6, 600, 5, 6, 100, 399, 100, 128, 228, 128, 356, 44, 5, 5000);
        vecs[2] = mk(p6(-50, 700, 700, -50, -50, -50), p6(-3, -3, 2, 2, 2, -3),
                     15, 1920, 0, 2, 0, 639, 0, 128, 128, 128, 256, 128, 0, 5000);
        vecs[3] = mk(p6(0, 50, 50, 0, 0, 0), p6(-20, -20, -5, -5, -5, -20),
                     0, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 10);

        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        vx_in = '0; vy_in = '0; m_in = '0; m_inv_in = '0;
        repeat (3) @(posedge clk100);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_txn_init", int'(bus.txn_init), 0);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_pc", int'(bus.pixel_count), 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk100);

        // Axis-aligned polygons: square, wide span, clipped, fully off-screen.
        for (int i = 0; i < 4; i++) begin
            base = nb; d0 = done_cnt; s0 = stable_err;
            vx_in = vecs[i].vx; vy_in = vecs[i].vy; m_in = '0; m_inv_in = '0;
            resp_delay = i;
            run_fill(0, lat, to);
            vx_in = '0; vy_in = '0;
            n = nb - base;
            pix = 0; xlo = -1; xhi = -1;
            for (int j = 0; j < n && base + j < 256; j++) begin
                pix += rec_pc[base + j];
                if (xlo < 0 || rec_x[base + j] < xlo) xlo = rec_x[base + j];
                if (rec_x[base + j] + rec_pc[base + j] - 1 > xhi) xhi = rec_x[base + j] + rec_pc[base + j] - 1;
            end
            chk($sformatf("v%0d_timeout", i), int'(to), 0);
            chk($sformatf("v%0d_bursts", i), n, vecs[i].e_n);
            chk($sformatf("v%0d_pixels", i), pix, vecs[i].e_pix);
            chk($sformatf("v%0d_first_y", i), (n > 0) ? rec_y[base] : -1, vecs[i].e_fy);
            chk($sformatf("v%0d_last_y", i), (n > 0) ? rec_y[base + n - 1] : -1, vecs[i].e_ly);
            chk($sformatf("v%0d_xlo", i), xlo, vecs[i].e_xlo);
            chk($sformatf("v%0d_xhi", i), xhi, vecs[i].e_xhi);
            chk($sformatf("v%0d_x0", i), (n > 0) ? rec_x[base] : -1, vecs[i].e_x0);
            chk($sformatf("v%0d_pc0", i), (n > 0) ? rec_pc[base] : -1, vecs[i].e_pc0);
            chk($sformatf("v%0d_x1", i), (n > 1) ? rec_x[base + 1] : -1, vecs[i].e_x1);
            chk($sformatf("v%0d_pc1", i), (n > 1) ? rec_pc[base + 1] : -1, vecs[i].e_pc1);
            chk($sformatf("v%0d_x2", i), (n > 2) ? rec_x[base + 2] : -1, vecs[i].e_x2);
            chk($sformatf("v%0d_pc2", i), (n > 2) ? rec_pc[base + 2] : -1, vecs[i].e_pc2);
            chk($sformatf("v%0d_y2", i), (n > 2) ? rec_y[base + 2] : -1, vecs[i].e_y2);
            chk($sformatf("v%0d_dones", i), done_cnt - d0, 1);
            chk($sformatf("v%0d_latency_ok", i), int'(lat <= vecs[i].e_lat), 1);
            chk($sformatf("v%0d_stable", i), stable_err - s0, 0);
        end

        // Hexagon with exactly representable slopes; start re-pulsed while busy.
        base = nb; d0 = done_cnt;
        vx_in    = p6(120, 160, 180, 160, 120, 100);
        vy_in    = p6(100, 100, 140, 180, 180, 140);
        m_in     = p6(0, 8192, -8192, 0, 8192, -8192);
        m_inv_in = p6(0, 2048, -2048, 0, 2048, -2048);
        resp_delay = 0;
        run_fill(40, lat, to);
        chk("hex_timeout", int'(to), 0);
        chk("hex_rows", nb - base, 81);
        chk("hex_dones", done_cnt - d0, 1);
        repeat (20) @(posedge clk100);
        #2;
        chk("hex_no_restart_busy", int'(busy), 0);
        chk("hex_no_restart_bursts", nb - base, 81);
        for (int i = 0; i < 81 && i < nb - base; i++) begin
            yr = real'(rec_y[base + i]);
            xl = (yr <= 140.0) ? 120.0 - (yr - 100.0) / 2.0 : 100.0 + (yr - 140.0) / 2.0;
            xr = (yr <= 140.0) ? 160.0 + (yr - 100.0) / 2.0 : 180.0 - (yr - 140.0) / 2.0;
            xs = real'(rec_x[base + i]);
            xe = real'(rec_x[base + i] + rec_pc[base + i] - 1);
            total++;
            if (rec_y[base + i] != 100 + i || xs - xl > 1.0 || xl - xs > 1.0 ||
                xe - xr > 1.0 || xr - xe > 1.0) begin
                bad++;
                $display("FAIL hex_row%0d: y=%0d x=%0d end=%0d required y=%0d x~%0.1f end~%0.1f",
                         i, rec_y[base + i], rec_x[base + i], rec_x[base + i] + rec_pc[base + i] - 1,
                         100 + i, xl, xr);
            end
        end

        // Abort latched during a burst takes effect on txn_done.
        base = nb; d0 = done_cnt;
        vx_in = vecs[0].vx; vy_in = vecs[0].vy; m_in = '0; m_inv_in = '0;
        resp_delay = 6;
        seen = 1'b0;
        @(posedge clk100);
        #2 start = 1'b1;
        for (c = 0; c < 200; c++) begin
            @(posedge clk100);
            #2;
            if (c == 2) start = 1'b0;
            if (bus.txn_init) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("abort_burst_seen", int'(seen), 1);
        abort = 1'b1;
        @(posedge clk100);
        #2 abort = 1'b0;
        chk("abort_burst_held", int'(bus.txn_init), 1);
        seen = 1'b0;
        for (c = 0; c < 50; c++) begin
            @(posedge clk100);
            #2;
            if (bus.txn_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_txn_done_seen", int'(seen), 1);
        chk("abort_init_at_done", int'(bus.txn_init), 1);
        @(posedge clk100);
        #2;
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_init", int'(bus.txn_init), 0);
        repeat (30) @(posedge clk100);
        #2;
        chk("abort_bursts", nb - base, 1);
        chk("abort_no_done", done_cnt - d0, 0);

        // Reset in the middle of a burst clears everything.
        base = nb;
        resp_delay = 20;
        seen = 1'b0;
        @(posedge clk100);
        #2 start = 1'b1;
        for (c = 0; c < 200; c++) begin
            @(posedge clk100);
            #2;
            if (c == 2) start = 1'b0;
            if (bus.txn_init) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("mrst_burst_seen", int'(seen), 1);
        resetn = 1'b0;
        @(posedge clk100);
        #2;
        chk("mrst_init", int'(bus.txn_init), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_x", bus.x, 0);
        chk("mrst_y", bus.y, 0);
        chk("mrst_pc", int'(bus.pixel_count), 0);
        resetn = 1'b1;
        repeat (30) @(posedge clk100);
        #2;
        chk("mrst_stays_idle", int'(busy), 0);
        chk("mrst_bursts", nb - base, 1);

        chk("burst_stable_all", stable_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/convex_polygon_filler.md
CONVEX_POLYGON_FILLER -- requirements
Module: convex_polygon_filler

Interface
REQ-001 Parameter NUM_VERTS, default 6, shall set the vertex and edge count (3..8); edge i runs from vertex i to vertex (i+1) mod NUM_VERTS.
REQ-002 Parameter BURST_LEN, default 128, shall set the maximum pixels per burst (1..256).
REQ-003 Parameter FRAC_BITS, default 12, shall set the fractional bits of slope inputs.
REQ-004 Parameters SCREEN_W, default 640, and SCREEN_H, default 480, shall set the clip rectangle [0,SCREEN_W-1]x[0,SCREEN_H-1].
REQ-005 clk100  in  1  clock; all logic on rising edge.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  level; rising edge requests a fill.
REQ-008 abort  in  1  level; cancels the current fill.
REQ-009 vx_in, vy_in  in  32*NUM_VERTS each  signed integer vertex coordinates, vertex k in bits [32k+31:32k].
REQ-010 m_in, m_inv_in  in  32*NUM_VERTS each  signed fixed-point slope and inverse slope for edge k.
REQ-011 txn_init  out  1  high while a burst is requested.
REQ-012 txn_done  in  1  one-cycle pulse; the burst has completed.
REQ-013 x, y  out  32 each  signed start pixel of the current burst.
REQ-014 pixel_count  out  32  burst length, 1..BURST_LEN.
REQ-015 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-016 The start rising edge shall be detected with a two-flop edge detector; start edges shall be ignored while busy.
REQ-017 States shall be IDLE, LOAD, OFFSET_MUL, OFFSET_SUB, Y_RANGE, ROW_INIT, ISECT_MUL, ISECT_SEL, X_RANGE, BURST_SET, BURST, BURST_NEXT, ROW_NEXT and DONE, traversed in that order.
REQ-018 LOAD shall register all vertex and slope inputs; later input changes shall have no effect until the next LOAD.
REQ-019 The offset for edge k shall be b_k = vy_k - ((m_k*vx_k) >>> FRAC_BITS), using a 64-bit signed product truncated to 32 bits.
REQ-020 Y_RANGE shall compute y_min and y_max over all vertices and clip them to [0,SCREEN_H-1]; if y_min > y_max after clipping, the block shall go directly to DONE.
REQ-021 Rows y_min..y_max inclusive shall be scanned in ascending order.
REQ-022 Edge k shall be valid on row y when it is not horizontal and y lies between its endpoint y values, inclusive.
REQ-023 The intersection shall be the exact endpoint x when y equals an endpoint y; vx_k when the edge is vertical; otherwise ((y-b_k)*m_inv_k) >>> FRAC_BITS, 64-bit and truncated.
REQ-024 X_RANGE shall take the span min/max over valid edges only and clip it to [0,SCREEN_W-1].
REQ-025 If no edge is valid, or the clipped x_min > x_max, the row shall emit no burst and go to ROW_NEXT.
REQ-026 BURST_SET shall set pixel_count = min(BURST_LEN, x_max-x+1).
REQ-027 In BURST, txn_init, x, y and pixel_count shall be held stable until txn_done is sampled high.
REQ-028 BURST_NEXT shall advance x by BURST_LEN and return to BURST_SET while x+BURST_LEN <= x_max; otherwise it shall go to ROW_NEXT.
REQ-029 ROW_NEXT shall increment y and go to ROW_INIT while y < y_max; otherwise it shall go to DONE.
REQ-030 DONE shall assert done for exactly one cycle, then return to IDLE.
REQ-031 Abort in any busy state other than BURST shall return the block to IDLE on the next edge without a done pulse.
REQ-032 Abort during BURST shall be latched and take effect on txn_done; the outstanding burst shall never be cut short.
REQ-033 A txn_done seen outside BURST shall be ignored.

Reset
REQ-034 While resetn is low, state shall be IDLE and txn_init, done, busy, x, y, pixel_count and all internal registers shall be 0, including a reset in mid-burst.

Structure
REQ-035 The state encodings and a slope fixed-point width constant shall live in the shared package hexagon_render_pkg.
REQ-036 The per-edge offset, intersection and valid logic shall be a sub-module edge_intersect, instantiated NUM_VERTS times.

Verification
REQ-037 Axis-aligned square (10,10),(20,10),(20,20),(10,20) with NUM_VERTS=4 -> rows 10..20 each give one burst x=10, pixel_count=11, then a single done pulse.
REQ-038 Span width 300 with BURST_LEN=128 -> bursts of 128, 128 and 44 at x, x+128 and x+256 on the same row.
REQ-039 Polygon spanning x=-50..700 -> every burst lies within x 0..639 and totals 640 pixels per row.
REQ-040 Polygon entirely at y<0 -> done within 10 cycles and txn_init never asserted.
REQ-041 Abort raised mid-BURST, txn_done 5 cycles later -> IDLE one cycle after txn_done, no done pulse, no further bursts.
REQ-042 Regular hexagon, NUM_VERTS=6 -> per-row spans match a software model within +/-1 pixel, and a start edge while busy is ignored.
